// File: rtl/cayde_pkg.sv
// Shared definitions for the cayde ALU issue stage.
// Holds the ALU op codes driven towards the ALU, the RV32I major opcodes and
// funct7 values the decoder recognises, and the packed issue packet that
// travels from the decoder through the skid buffer to the outputs.
package cayde_pkg;

    // ALU op codes. Codes 5 and 7 are reserved and never produced.
    localparam logic [6:0] ALU_ADD = 7'd0;
    localparam logic [6:0] ALU_SUB = 7'd1;
    localparam logic [6:0] ALU_XOR = 7'd2;
    localparam logic [6:0] ALU_AND = 7'd3;
    localparam logic [6:0] ALU_OR  = 7'd4;
    localparam logic [6:0] ALU_SLL = 7'd6;
    localparam logic [6:0] ALU_SRL = 7'd8;
    localparam logic [6:0] ALU_SRA = 7'd9;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values: base encoding and the SUB/SRA alternate encoding
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One issue packet as presented to the ALU
    typedef struct packed {
        logic [6:0]  alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        illegal;
    } issue_pkt_t;

    // Packet issued for anything the decoder does not support: every field
    // zeroed so nothing downstream can act on stale operands.
    function automatic issue_pkt_t illegal_pkt();
        issue_pkt_t p;
        p.alu_op  = ALU_ADD;
        p.op_a    = '0;
        p.op_b    = '0;
        p.rd      = '0;
        p.illegal = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/cayde_issue_decode.sv
// Combinational RV32I decoder for the ALU issue stage.
// Maps one instruction word plus its register read data and PC onto an
// issue packet (ALU op, operand A, operand B, rd, illegal flag).
// Ports:
//   instr_i     instruction word
//   pc_i        instruction PC (operand A of AUIPC)
//   rs1_data_i  rs1 read data
//   rs2_data_i  rs2 read data (shift amount source for register shifts)
//   pkt_o       decoded issue packet
module cayde_issue_decode
    import cayde_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output issue_pkt_t  pkt_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] immI;
    logic [31:0] immU;
    logic [31:0] shamtReg;
    logic [31:0] shamtImm;

    logic        legal;
    logic [6:0]  aluOp;
    logic [31:0] opA;
    logic [31:0] opB;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign immI     = {{20{instr_i[31]}}, instr_i[31:20]};
    assign immU     = {instr_i[31:12], 12'b0};
    assign shamtReg = {27'b0, rs2_data_i[4:0]};
    assign shamtImm = {27'b0, instr_i[24:20]};

    // Anything not explicitly recognised below leaves legal low, including
    // SLT/SLTU/SLTI/SLTIU and words whose low two bits are not 2'b11.
    always_comb begin
        legal = 1'b0;
        aluOp = ALU_ADD;
        opA   = '0;
        opB   = '0;
        if (instr_i[1:0] == 2'b11) begin
            case (opcode)
                OPC_OP: begin
                    opA = rs1_data_i;
                    opB = rs2_data_i;
                    if (funct7 == F7_BASE) begin
                        legal = 1'b1;
                        case (funct3)
                            3'b000:  aluOp = ALU_ADD;
                            3'b100:  aluOp = ALU_XOR;
                            3'b110:  aluOp = ALU_OR;
                            3'b111:  aluOp = ALU_AND;
                            3'b001: begin
                                aluOp = ALU_SLL;
                                opB   = shamtReg;
                            end
                            3'b101: begin
                                aluOp = ALU_SRL;
                                opB   = shamtReg;
                            end
                            default: legal = 1'b0;
                        endcase
                    end else if (funct7 == F7_ALT) begin
                        legal = 1'b1;
                        case (funct3)
                            3'b000:  aluOp = ALU_SUB;
                            3'b101: begin
                                aluOp = ALU_SRA;
                                opB   = shamtReg;
                            end
                            default: legal = 1'b0;
                        endcase
                    end
                end
                OPC_OP_IMM: begin
                    opA = rs1_data_i;
                    opB = immI;
                    case (funct3)
                        3'b000: begin
                            aluOp = ALU_ADD;
                            legal = 1'b1;
                        end
                        3'b100: begin
                            aluOp = ALU_XOR;
                            legal = 1'b1;
                        end
                        3'b110: begin
                            aluOp = ALU_OR;
                            legal = 1'b1;
                        end
                        3'b111: begin
                            aluOp = ALU_AND;
                            legal = 1'b1;
                        end
                        3'b001: begin
                            aluOp = ALU_SLL;
                            opB   = shamtImm;
                            legal = (funct7 == F7_BASE);
                        end
                        // SRLI and SRAI share funct3; funct7 picks the variant
                        3'b101: begin
                            opB = shamtImm;
                            if (funct7 == F7_BASE) begin
                                aluOp = ALU_SRL;
                                legal = 1'b1;
                            end else if (funct7 == F7_ALT) begin
                                aluOp = ALU_SRA;
                                legal = 1'b1;
                            end
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_LUI: begin
                    aluOp = ALU_ADD;
                    opA   = '0;
                    opB   = immU;
                    legal = 1'b1;
                end
                OPC_AUIPC: begin
                    aluOp = ALU_ADD;
                    opA   = pc_i;
                    opB   = immU;
                    legal = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Illegal packets carry no operand data at all
    always_comb begin
        if (legal) begin
            pkt_o.alu_op  = aluOp;
            pkt_o.op_a    = opA;
            pkt_o.op_b    = opB;
            pkt_o.rd      = instr_i[11:7];
            pkt_o.illegal = 1'b0;
        end else begin
            pkt_o = illegal_pkt();
        end
    end

endmodule

// File: rtl/cayde_alu_issue.sv
// Decode/issue stage feeding the combinational ALU.
// Accepts one instruction per cycle with its operands, decodes it and holds
// the result in a two-entry skid buffer behind a registered valid/ready
// output. Entry 0 drives the outputs, entry 1 absorbs one packet while the
// consumer stalls. A saturating counter tracks illegal packets issued.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_valid_i          instruction/operands valid
//   in_ready_o          stage can accept (registered, low when entry 1 full)
//   instr_i, pc_i       instruction word and its PC
//   rs1_data_i          rs1 read data
//   rs2_data_i          rs2 read data
//   out_valid_o         issue packet valid
//   out_ready_i         consumer accepts packet
//   alu_op_o            ALU op code
//   op_a_o, op_b_o      ALU operands
//   rd_o                destination register
//   illegal_o           packet is an illegal/unsupported instruction
//   illegal_cnt_o       saturating count of illegal packets issued
module cayde_alu_issue
    import cayde_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [6:0]       alu_op_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic [4:0]       rd_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    issue_pkt_t       decPkt;
    issue_pkt_t       ent0_q, ent0_d;
    issue_pkt_t       ent1_q, ent1_d;
    logic             ent0Valid_q, ent0Valid_d;
    logic             ent1Valid_q, ent1Valid_d;
    logic             inReady_q;
    logic [CNT_W-1:0] illCnt_q, illCnt_d;
    logic             accept;
    logic             drain;

    cayde_issue_decode uDecode (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .pkt_o      (decPkt)
    );

    assign accept = in_valid_i && inReady_q;
    assign drain  = ent0Valid_q && out_ready_i;

    // Skid buffer next state. Because in_ready is low whenever entry 1 is
    // full, an accept can never coincide with entry 1 being occupied, so a
    // drain either promotes entry 1 or lets the new packet replace entry 0.
    always_comb begin
        ent0_d      = ent0_q;
        ent0Valid_d = ent0Valid_q;
        ent1_d      = ent1_q;
        ent1Valid_d = ent1Valid_q;
        if (drain) begin
            if (ent1Valid_q) begin
                ent0_d      = ent1_q;
                ent1Valid_d = 1'b0;
            end else if (accept) begin
                ent0_d = decPkt;
            end else begin
                ent0Valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!ent0Valid_q) begin
                ent0_d      = decPkt;
                ent0Valid_d = 1'b1;
            end else begin
                ent1_d      = decPkt;
                ent1Valid_d = 1'b1;
            end
        end
    end

    // Count illegal packets as they leave, holding at all-ones
    always_comb begin
        illCnt_d = illCnt_q;
        if (drain && ent0_q.illegal && (illCnt_q != {CNT_W{1'b1}})) begin
            illCnt_d = illCnt_q + CNT_W'(1);
        end
    end

    // Reset empties both entries and zeroes the visible payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent0_q      <= '0;
            ent1_q      <= '0;
            ent0Valid_q <= 1'b0;
            ent1Valid_q <= 1'b0;
            inReady_q   <= 1'b1;
            illCnt_q    <= '0;
        end else begin
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            ent0Valid_q <= ent0Valid_d;
            ent1Valid_q <= ent1Valid_d;
            inReady_q   <= !ent1Valid_d;
            illCnt_q    <= illCnt_d;
        end
    end

    assign in_ready_o    = inReady_q;
    assign out_valid_o   = ent0Valid_q;
    assign alu_op_o      = ent0_q.alu_op;
    assign op_a_o        = ent0_q.op_a;
    assign op_b_o        = ent0_q.op_b;
    assign rd_o          = ent0_q.rd;
    assign illegal_o     = ent0_q.illegal;
    assign illegal_cnt_o = illCnt_q;

endmodule

// File: doc/cayde_alu_issue.md
Name: cayde_alu_issue

Overview:
- Decode/issue stage that drives the ALU.
- Accepts one RV32I integer instruction per cycle, together with its register-file read data and PC.
- Translates each instruction into an ALU op code, op_a and op_b, and holds the result in a registered valid/ready output with a 2-entry skid buffer.
- Sits between register-file read and the combinational ALU. It is the producer side of the op_i/op_a/op_b interface.

Parameters:
- CNT_W, 16, width of the illegal-instruction counter (saturating).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- in_valid_i  input  1  instruction/operands valid
- in_ready_o  output  1  stage can accept
- instr_i  input  32  instruction word
- pc_i  input  32  instruction PC
- rs1_data_i  input  32  rs1 read data
- rs2_data_i  input  32  rs2 read data
- out_valid_o  output  1  issue packet valid
- out_ready_i  input  1  ALU/writeback accepts packet
- alu_op_o  output  7  ALU op code
- op_a_o  output  32  ALU operand A
- op_b_o  output  32  ALU operand B
- rd_o  output  5  destination register
- illegal_o  output  1  packet is an illegal/unsupported instruction
- illegal_cnt_o  output  CNT_W  saturating count of illegal packets issued

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - out_valid_o=0, in_ready_o=1, illegal_cnt_o=0.
  - alu_op_o, op_a_o, op_b_o, rd_o and illegal_o are all 0.
  - Both skid entries are empty.
- Reset mid-operation drops all buffered packets. No partial packet is ever emitted.
- ALU op codes (7 bits): ADD=0, SUB=1, XOR=2, AND=3, OR=4, SLL=6, SRL=8, SRA=9. Codes 5 and 7 are never generated.
- Handshake rules:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - Output payload is stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput: 1 cycle from input transfer to out_valid_o. Full throughput of 1/cycle while out_ready_i=1.
- Skid buffer:
  - Entry 0 drives the outputs; entry 1 is the skid entry.
  - in_ready_o is registered and equals !entry1_valid.
  - A packet accepted while entry 0 is occupied and not draining goes to entry 1.
  - On drain, entry 1 moves to entry 0.
  - Simultaneous accept and drain with only entry 0 full: the new packet replaces entry 0 with no bubble.
- Decode rules (instr_i[1:0] must be 2'b11, otherwise illegal):
  - OP (0110011):
    - funct7=0000000: funct3 000 ADD, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL.
    - funct7=0100000: funct3 000 SUB, 101 SRA.
    - a=rs1, b=rs2 except for shifts.
  - OP-IMM (0010011):
    - ADDI, XORI, ORI, ANDI use b=sign-extended imm[31:20].
    - SLLI/SRLI need funct7=0000000; SRAI needs funct7=0100000.
  - LUI (0110111): ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, a=pc_i, b={instr[31:12],12'b0}.
  - Shifts (register and immediate): b={27'b0, shamt}, where shamt=rs2_data_i[4:0] or instr[24:20].
  - rd_o=instr[11:7].
- Illegal/unsupported instructions:
  - Any other opcode, any other funct3/funct7 combination, SLT/SLTU/SLTI/SLTIU, and bad instr[1:0].
  - The packet is still issued with illegal_o=1, alu_op_o=0, op_a_o=0, op_b_o=0, rd_o=0.
  - illegal_cnt_o increments on output transfer of an illegal packet and saturates at all-ones (no wrap).
- rd=x0 packets are issued normally. Suppressing the write is the consumer's responsibility.

Decomposition:
- Package cayde_pkg:
  - ALU op code localparams (ADD..SRA, 7-bit).
  - RV32I opcode constants (OP, OP_IMM, LUI, AUIPC).
  - funct7 constants (0000000, 0100000).
  - Packed issue-packet struct: alu_op, op_a, op_b, rd, illegal.
- One natural sub-module: cayde_issue_decode, a purely combinational mapping from instruction + operands to the issue packet. The top contains the skid buffer and counter.

Test Plan:
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7, out_ready_i=1 -> next cycle out_valid_o=1, alu_op_o=0, op_a_o=5, op_b_o=7, rd_o=3, illegal_o=0.
- SRAI x4,x1,3 (instr 0x4030D213), rs1=0x80000000 -> alu_op_o=9, op_a_o=0x80000000, op_b_o=3. SRA with rs2=0xFFFFFF25 -> op_b_o=5.
- AUIPC x5,0x12345 with pc_i=0x100 -> alu_op_o=0, op_a_o=0x100, op_b_o=0x12345000, rd_o=5.
- Back-to-back stream of 4 ADDIs; hold out_ready_i=0 for 3 cycles:
  - in_ready_o falls after 2 packets are buffered.
  - On release, the packets emerge in order, none lost or duplicated, payload stable while stalled.
- SLT x1,x2,x3, then opcode 0x0000000F -> two packets with illegal_o=1 and zeroed fields, illegal_cnt_o=2. With CNT_W=2, 5 illegal packets -> counter holds at 3.
- Assert rst_i asynchronously while 2 packets are buffered -> out_valid_o=0 and in_ready_o=1 immediately, with no packet emitted after release.
